// File: rtl/ica_moment_accum_pkg.sv
// ica_pkg: shared types and constants for the ICA moment accumulator.
package ica_pkg;
  typedef logic signed [15:0] sample_t;
  typedef logic signed [31:0] prod_t;
  typedef logic signed [63:0] acc_t;
  typedef logic signed [63:0] moment_t;
  typedef enum logic [1:0] {IDLE, ACCUM, FINISH, DONE} state_t;
  localparam moment_t ONE_Q61 = 64'sd1 <<< 61;
endpackage

// File: rtl/ica_moment_accum_if.sv
// ica_moment_accum_if: sample stream, control and moment-matrix bundle.
interface ica_moment_accum_if;
  import ica_pkg::*;
  logic start, in_valid, in_ready, busy, done;
  sample_t y [3];
  moment_t h [3][3];
  moment_t p [3][3];
  modport master(output start, y, in_valid, input in_ready, h, p, busy, done);
  modport slave(input start, y, in_valid, output in_ready, h, p, busy, done);
endinterface

// File: rtl/ica_moment_accum_hardtanh.sv
// ica_hardtanh: g(v) = sat16(2*v); doubling overflows exactly when the top two bits differ.
module ica_hardtanh
  import ica_pkg::*;
(
  input  sample_t v_i,
  output sample_t g_o
);
  assign g_o = (v_i[15] ^ v_i[14]) ? {v_i[15], {15{~v_i[15]}}} : {v_i[14:0], 1'b0};
endmodule

// File: rtl/ica_moment_accum.sv
// ica_moment_accum: streams 3-element samples into block means of y_i*g(y_j) and y_i*y_j in Q2.61.
module ica_moment_accum
  import ica_pkg::*;
#(
  parameter int LOG2_N    = 8,
  parameter int OUT_SHIFT = 31
) (
  input logic clk,
  input logic rst,
  ica_moment_accum_if.slave bus
);
  localparam logic [LOG2_N:0] N = {1'b1, {LOG2_N{1'b0}}};
  state_t state_q, state_d;
  logic [LOG2_N:0] cnt_q;
  logic v1_q, done_q, hs, clr;
  sample_t g [3];
  prod_t ph_q [3][3];
  prod_t pp_q [3][3];
  acc_t ah_q [3][3];
  acc_t ap_q [3][3];
  moment_t h_q [3][3];
  moment_t p_q [3][3];
  for (genvar i = 0; i < 3; i++) begin : g_ht
    ica_hardtanh u_ht (.v_i(bus.y[i]), .g_o(g[i]));
  end
  // Drain happens the cycle the Nth product sits in stage 1; the adder consumes it on that edge.
  always_comb begin
    bus.in_ready = (state_q == ACCUM) && (cnt_q != N);
    hs = bus.in_valid && bus.in_ready;
    clr = bus.start && (state_q == IDLE || state_q == DONE);
    state_d = clr ? ACCUM
            : (state_q == ACCUM && cnt_q == N && v1_q) ? FINISH
            : (state_q == FINISH) ? DONE
            : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      v1_q <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          ph_q[i][j] <= '0;
          pp_q[i][j] <= '0;
          ah_q[i][j] <= '0;
          ap_q[i][j] <= '0;
          h_q[i][j] <= '0;
          p_q[i][j] <= '0;
        end
    end else begin
      state_q <= state_d;
      done_q <= state_q == FINISH;
      v1_q <= hs;
      if (clr) cnt_q <= '0;
      else if (hs) cnt_q <= cnt_q + 1'b1;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          if (hs) begin
            ph_q[i][j] <= prod_t'(bus.y[i]) * prod_t'(g[j]);
            pp_q[i][j] <= prod_t'(bus.y[i]) * prod_t'(bus.y[j]);
          end
          if (clr) begin
            ah_q[i][j] <= '0;
            ap_q[i][j] <= '0;
          end else if (v1_q) begin
            ah_q[i][j] <= ah_q[i][j] + acc_t'(ph_q[i][j]);
            ap_q[i][j] <= ap_q[i][j] + acc_t'(pp_q[i][j]);
          end
          if (state_q == FINISH) begin
            h_q[i][j] <= (ah_q[i][j] >>> LOG2_N) <<< OUT_SHIFT;
            p_q[i][j] <= (ap_q[i][j] >>> LOG2_N) <<< OUT_SHIFT;
          end
        end
    end
  end
  assign bus.busy = (state_q == ACCUM) || (state_q == FINISH);
  assign bus.done = done_q;
  assign bus.h = h_q;
  assign bus.p = p_q;
endmodule

// File: tb/tb_ica_moment_accum.sv
// tb_ica_moment_accum: directed checks of block means, handshake timing, reset and start handling.
module tb_ica_moment_accum;
  logic clk = 1'b0;
  logic rst;
  int comps = 0;
  int fails = 0;
  longint ha00, two61;
  ica_moment_accum_if bus();
  ica_moment_accum #(.LOG2_N(2), .OUT_SHIFT(31)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input longint obs, input longint exp);
    comps++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic longint gm(input longint x);
    longint d = 2 * x;
    return d > 32767 ? 32767 : (d < -32768 ? -32768 : d);
  endfunction
  task automatic set_y(input longint a0, input longint a1, input longint a2);
    bus.y[0] = 16'(a0);
    bus.y[1] = 16'(a1);
    bus.y[2] = 16'(a2);
  endtask
  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask
  task automatic check_const(input longint a0, input longint a1, input longint a2);
    longint a [3];
    a = '{a0, a1, a2};
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        chk($sformatf("p[%0d][%0d]", i, j), bus.p[i][j], (a[i] * a[j]) <<< 31);
        chk($sformatf("h[%0d][%0d]", i, j), bus.h[i][j], (a[i] * gm(a[j])) <<< 31);
      end
  endtask
  task automatic feed(input longint a0, input longint a1, input longint a2, input logic [15:0] pat,
                      input int nsamp, input int st_at, input longint prev_h00);
    int n = 0;
    int i = 0;
    logic hs;
    set_y(a0, a1, a2);
    while (n < nsamp && i < 64) begin
      bus.in_valid = pat[i % 16];
      bus.start = (i == st_at);
      hs = bus.in_valid && bus.in_ready;
      step();
      if (hs) n++;
      i++;
    end
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    chk("handshakes", n, nsamp);
    if (nsamp == 4) begin
      set_y(7, 7, 7);
      bus.in_valid = 1'b1;
      chk("in_ready_after_n", bus.in_ready, 0);
      chk("busy_k1", bus.busy, 1);
      chk("done_k1", bus.done, 0);
      step();
      chk("busy_finish", bus.busy, 1);
      chk("done_finish", bus.done, 0);
      chk("h00_hold_finish", bus.h[0][0], prev_h00);
      step();
      chk("done_k3", bus.done, 1);
      chk("busy_done", bus.busy, 0);
      bus.in_valid = 1'b0;
      step();
      chk("done_k4", bus.done, 0);
    end
  endtask
  initial begin
    two61 = 64'sd1 <<< 61;
    ha00 = longint'(536854528) <<< 31;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    set_y(0, 0, 0);
    step();
    step();
    chk("rst_h00", bus.h[0][0], 0);
    chk("rst_p22", bus.p[2][2], 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    rst = 1'b0;
    step();
    // Block A: start with a simultaneous valid sample that must be dropped
    set_y(16384, 0, -16384);
    bus.start = 1'b1;
    bus.in_valid = 1'b1;
    step();
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    chk("accum_in_ready", bus.in_ready, 1);
    chk("accum_busy", bus.busy, 1);
    feed(16384, 0, -16384, 16'hFFFF, 4, -1, 0);
    chk("A_p00", bus.p[0][0], 64'sd1 <<< 59);
    chk("A_p02", bus.p[0][2], -(64'sd1 <<< 59));
    chk("A_p11", bus.p[1][1], 0);
    chk("A_h00", bus.h[0][0], ha00);
    chk("A_h02", bus.h[0][2], -(64'sd1 <<< 60));
    chk("A_h20", bus.h[2][0], -ha00);
    check_const(16384, 0, -16384);
    // Block B: same data with gaps in in_valid
    pulse_start();
    feed(16384, 0, -16384, 16'b0000000001101001, 4, -1, ha00);
    check_const(16384, 0, -16384);
    // Block C: negative full scale everywhere
    pulse_start();
    feed(-32768, -32768, -32768, 16'hFFFF, 4, -1, ha00);
    chk("C_p11", bus.p[1][1], two61);
    chk("C_h21", bus.h[2][1], two61);
    check_const(-32768, -32768, -32768);
    // Block D: stray start mid-block is ignored
    pulse_start();
    feed(16384, 0, -16384, 16'hFFFF, 4, 2, two61);
    check_const(16384, 0, -16384);
    // Block E: zero samples; old results hold until FINISH
    pulse_start();
    chk("E_h00_hold_accum", bus.h[0][0], ha00);
    feed(0, 0, 0, 16'hFFFF, 4, -1, ha00);
    check_const(0, 0, 0);
    // Block F: reset mid-block, then a clean block
    pulse_start();
    feed(5000, -3000, 100, 16'hFFFF, 2, -1, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("F_rst_h00", bus.h[0][0], 0);
    chk("F_rst_p00", bus.p[0][0], 0);
    chk("F_rst_busy", bus.busy, 0);
    chk("F_rst_in_ready", bus.in_ready, 0);
    chk("F_rst_done", bus.done, 0);
    pulse_start();
    feed(16384, 0, -16384, 16'hFFFF, 4, -1, 0);
    check_const(16384, 0, -16384);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
    $finish;
  end
endmodule
